// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a 5-stage in-order pipeline.
// Optional macro FWD_WB_EN enables forwarding from the MEM/WB result (select 10); without it MEM producers stall.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              ex_flush,
  output logic              stall,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } stage_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  stage_t ex_q, mem_q, wb_q;
  stage_t id_s;

  logic       ex_a, ex_b, mem_a, mem_b;
  logic       load_hit, mem_wait, issue;
  logic [1:0] fwd_a, fwd_b;

  // Register 0 is hard-wired to zero, so it can never be a real producer.
  function automatic logic writes(input stage_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.we && (s.rd == r) && (r != '0);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    id_s     = '{valid: id_valid, rd: id_rd, we: id_we, is_load: id_is_load};
    ex_a     = id_rs_used && writes(ex_q, id_rs);
    ex_b     = id_rt_used && writes(ex_q, id_rt);
    mem_a    = id_rs_used && writes(mem_q, id_rs);
    mem_b    = id_rt_used && writes(mem_q, id_rt);
    load_hit = (ex_a || ex_b) && ex_q.is_load;
    mem_wait = 1'b0;
    fwd_a    = SEL_RF;
    fwd_b    = SEL_RF;
`ifdef FWD_WB_EN
    if (ex_a && !ex_q.is_load) fwd_a = SEL_EXM;
    else if (mem_a)            fwd_a = SEL_MWB;
    if (ex_b && !ex_q.is_load) fwd_b = SEL_EXM;
    else if (mem_b)            fwd_b = SEL_MWB;
`else
    // Without the MEM/WB path a MEM producer is waited out until it reaches WB,
    // unless a younger EX producer of the same register already supplies the value.
    mem_wait = (mem_a && !ex_a) || (mem_b && !ex_b);
    if (ex_a && !ex_q.is_load) fwd_a = SEL_EXM;
    if (ex_b && !ex_q.is_load) fwd_b = SEL_EXM;
`endif
    stall = !rst && id_valid && !ex_flush && (load_hit || mem_wait);
    issue = id_valid && !ex_flush && !stall;
  end

  // NOTE: state is updated with non-blocking assignments; reset clears tracking, selects and counter together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      sel_a       <= SEL_RF;
      sel_b       <= SEL_RF;
      stall_count <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= issue ? id_s : '0;
      sel_a <= issue ? fwd_a : SEL_RF;
      sel_b <= issue ? fwd_b : SEL_RF;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

  // The WB copy is read through the write-before-read register file, so it only needs to stay coherent.
  wb_follows_mem: assert property (@(posedge clk) disable iff (rst)
    wb_q.valid |-> (wb_q == $past(mem_q)));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl; expectations follow the FWD_WB_EN build setting.
module tb_fwd_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
`ifdef FWD_WB_EN
  localparam int LU_BUBBLES = 1;
`else
  localparam int LU_BUBBLES = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_rs_used, id_rt_used, id_we, id_is_load, ex_flush;
  logic              stall;
  logic [1:0]        sel_a, sel_b;
  logic [CNT_W-1:0]  stall_count;

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(stall), .sel_a(sel_a),
    .sel_b(sel_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         exp_cnt = 0;
  logic       st;
  logic [1:0] sa, sb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one ID instruction: stall sampled mid-cycle, selects sampled just after the edge.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ru, input logic tu, input logic [4:0] rd,
                      input logic we, input logic ld, input logic fl);
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = ru; id_rt_used = tu;
    id_rd = rd; id_we = we; id_is_load = ld; ex_flush = fl;
    #1 st = stall;
    @(posedge clk);
    #1;
    sa = sel_a;
    sb = sel_b;
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  task automatic expect_stall(input string tag, input logic e);
    check(tag, {31'd0, st}, {31'd0, e});
    if (e && exp_cnt < 15) exp_cnt++;
    check({tag, "_cnt"}, {28'd0, stall_count}, exp_cnt);
  endtask

  task automatic expect_sels(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    check({tag, "_sel_a"}, {30'd0, sa}, {30'd0, ea});
    check({tag, "_sel_b"}, {30'd0, sb}, {30'd0, eb});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    // Reset held two edges with random ID contents.
    rst = 1'b1;
    repeat (2) begin
      id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
      id_rs_used = 1'($urandom); id_rt_used = 1'($urandom); id_rd = 5'($urandom);
      id_we = 1'($urandom); id_is_load = 1'($urandom); ex_flush = 1'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_sel_a", {30'd0, sel_a}, 32'd0);
    check("rst_sel_b", {30'd0, sel_b}, 32'd0);
    check("rst_cnt", {28'd0, stall_count}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nop();
    expect_stall("post_rst_stall", 1'b0);

    // ALU chain: add r3,r1,r2 ; sub r4,r3,r5.
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_stall("chain_stall", 1'b0);
    expect_sels("chain", 2'b01, 2'b00);
    drain();

    // Distance-2: add r3 ; nop ; or r6,r5,r3.
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    nop();
    step(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
`ifdef FWD_WB_EN
    expect_stall("dist2_stall", 1'b0);
    expect_sels("dist2", 2'b00, 2'b10);
`else
    expect_stall("dist2_stall", 1'b1);
    expect_sels("dist2_bubble", 2'b00, 2'b00);
    step(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    expect_stall("dist2_retry_stall", 1'b0);
    expect_sels("dist2_retry", 2'b00, 2'b00);
`endif
    drain();

    // Load-use: lw r2,0(r1) ; add r7,r2,r2.
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    expect_stall("lu_stall1", 1'b1);
    expect_sels("lu_bubble1", 2'b00, 2'b00);
`ifdef FWD_WB_EN
    step(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    expect_stall("lu_go_stall", 1'b0);
    expect_sels("lu_go", 2'b10, 2'b10);
`else
    step(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    expect_stall("lu_stall2", 1'b1);
    step(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    expect_stall("lu_go_stall", 1'b0);
    expect_sels("lu_go", 2'b00, 2'b00);
`endif
    drain();

    // Writers of r3 in both EX and MEM: the younger EX copy wins.
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_stall("exmem_stall", 1'b0);
    expect_sels("exmem", 2'b01, 2'b00);
    drain();

    // Unused source A matching the EX writer stays on the register file.
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_sels("unused", 2'b00, 2'b01);
    drain();

    // Register 0 producers never match.
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    expect_stall("r0_stall", 1'b0);
    expect_sels("r0", 2'b00, 2'b00);
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    expect_stall("r0_load_stall", 1'b0);
    drain();

    // Flush beats a load-use hazard; the squashed add r7 must not reach EX.
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    expect_stall("flush_stall", 1'b0);
    expect_sels("flush", 2'b00, 2'b00);
    step(1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_stall("post_flush_stall", 1'b0);
    expect_sels("post_flush", 2'b00, 2'b00);
    drain();

    // Saturation: 20 load-use pairs on a 4-bit counter.
    do_reset();
    check("sat_start_cnt", {28'd0, stall_count}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
      repeat (LU_BUBBLES + 1) step(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    end
    check("sat_cnt", {28'd0, stall_count}, 32'd15);
    check("sat_last_stall", {31'd0, st}, 32'd0);

    // Reset while stalled discards the load and clears the counter.
    step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd2; id_rs_used = 1'b1; id_rt_used = 1'b1;
    id_rd = 5'd7; id_we = 1'b1; id_is_load = 1'b0; ex_flush = 1'b0;
    #1 check("mid_stall_before_rst", {31'd0, stall}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_cnt", {28'd0, stall_count}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_sel_a", {30'd0, sel_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
